// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_pkg                                                    |
// | Description : Shared types and default constants for the fetch stage.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fetch_pkg;

  // Default configuration of the fetch stage
  localparam int          DEF_ADDR_W   = 16;
  localparam int          DEF_INSTR_W  = 16;
  localparam int          DEF_QDEPTH   = 4;
  localparam int unsigned DEF_RESET_PC = 0;

  // FETCH allows new issues, HALTED suppresses them
  typedef enum logic [0:0] {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  // Prefetch-queue entry at the default widths
  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_ADDR_W-1:0]  pc_plus_1;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_fifo                                                   |
// | Description : Circular prefetch buffer with push, pop and sync flush.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = DEF_QDEPTH,
  parameter type T     = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  output T                       head_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_en;
  logic          pop_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  // Guard against overflow/underflow even if the caller misbehaves
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Entry storage: data registers need no reset, validity lives in count_q
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; flush empties
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push_en && !pop_en) begin
        count_q <= count_q + CW'(1);
      end else if (!push_en && pop_en) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_unit                                                   |
// | Description : Sequential instruction fetch with prefetch queue, redirect  |
// |               flush and halt.                                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = DEF_ADDR_W,
  parameter int          INSTR_W  = DEF_INSTR_W,
  parameter int          QDEPTH   = DEF_QDEPTH,
  parameter int unsigned RESET_PC = DEF_RESET_PC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hlt,
  input  logic                    alt_pc_ctrl,
  input  logic [ADDR_W-1:0]       alt_pc,
  output logic [ADDR_W-1:0]       imem_addr,
  output logic                    imem_rd_en,
  input  logic [INSTR_W-1:0]      imem_rdata,
  output logic [INSTR_W-1:0]      instr,
  output logic [ADDR_W-1:0]       pc_plus_1,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(QDEPTH):0] q_count
);

  localparam int                CW        = $clog2(QDEPTH) + 1;
  localparam logic [ADDR_W-1:0] RST_PC    = ADDR_W'(RESET_PC);
  localparam logic [CW:0]       DEPTH_LIM = (CW+1)'(QDEPTH);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_plus_1;
  } entry_t;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic              inflight_q, inflight_d;
  logic              issue;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CW-1:0]     count;
  logic [CW:0]       occupancy;
  entry_t            push_entry;
  entry_t            head_entry;

  // The outstanding response already owns a slot, so it counts as occupied
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};

  // A response arriving during a redirect is killed by not pushing it
  assign push                 = inflight_q & ~alt_pc_ctrl;
  assign push_entry.instr     = imem_rdata;
  assign push_entry.pc_plus_1 = tag_q + ADDR_W'(1);

  // Redirect discards the head, so a concurrent pop is ignored
  assign pop = ~fifo_empty & out_ready & ~alt_pc_ctrl;

  assign out_valid  = ~fifo_empty;
  assign instr      = fifo_empty ? '0 : head_entry.instr;
  assign pc_plus_1  = fifo_empty ? '0 : head_entry.pc_plus_1;
  assign q_count    = count;
  assign imem_addr  = pc_q;
  assign imem_rd_en = issue;

  // Next-state, issue decision and fetch-PC update
  always_comb begin
    state_d    = FETCH;
    pc_d       = pc_q;
    tag_d      = tag_q;
    issue      = 1'b0;
    inflight_d = 1'b0;
    if (hlt) begin
      state_d = HALTED;
    end
    if (!rst && (state_q == FETCH) && !hlt && !alt_pc_ctrl &&
        !fifo_full && (occupancy < DEPTH_LIM)) begin
      issue = 1'b1;
    end
    inflight_d = issue;
    if (alt_pc_ctrl) begin
      pc_d = alt_pc;
    end else if (issue) begin
      pc_d  = pc_q + ADDR_W'(1);
      tag_d = pc_q;
    end
  end

  // State, fetch PC and in-flight tracking registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RST_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH (QDEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (alt_pc_ctrl),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .head_o  (head_entry),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (count)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_unit                                                |
// | Description : Self-checking bench for fetch_unit (directed vectors).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        hlt;
  logic        alt_pc_ctrl;
  logic [15:0] alt_pc;
  logic [15:0] imem_addr;
  logic        imem_rd_en;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] instr;
  logic [15:0] pc_plus_1;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  q_count;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        hlt;
    logic        alt;
    logic [15:0] alt_pc;
    logic        rdy;
    logic        e_rd;
    logic [15:0] e_addr;
    logic        e_val;
    logic [15:0] e_instr;
    logic [15:0] e_pcp1;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  fetch_unit #(
    .ADDR_W   (16),
    .INSTR_W  (16),
    .QDEPTH   (4),
    .RESET_PC (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hlt         (hlt),
    .alt_pc_ctrl (alt_pc_ctrl),
    .alt_pc      (alt_pc),
    .imem_addr   (imem_addr),
    .imem_rd_en  (imem_rd_en),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .pc_plus_1   (pc_plus_1),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .q_count     (q_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: word k holds 0x1000 + k
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= 16'h1000 + imem_addr;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add_vec(input logic h, input logic a, input logic [15:0] ap, input logic r,
                         input logic e_rd, input logic [15:0] e_addr, input logic e_val,
                         input logic [15:0] e_instr, input logic [15:0] e_pcp1,
                         input logic [2:0] e_cnt);
    vec_t v;
    v.hlt = h; v.alt = a; v.alt_pc = ap; v.rdy = r;
    v.e_rd = e_rd; v.e_addr = e_addr; v.e_val = e_val;
    v.e_instr = e_instr; v.e_pcp1 = e_pcp1; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  // Wait (bounded) for the next valid head with out_ready high; lat = cycles waited
  task automatic next_out(input int bound, output logic ok, output logic [15:0] ins,
                          output logic [15:0] pcp, output int lat);
    ok = 1'b0; ins = '0; pcp = '0; lat = -1;
    out_ready = 1'b1;
    for (int k = 0; k < bound && !ok; k++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1; ins = instr; pcp = pc_plus_1; lat = k;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ok;
    logic        found;
    logic [15:0] ins;
    logic [15:0] pcp;
    int          lat;
    logic [15:0] got[$];

    //         h  a  alt_pc  r | rd  addr     v  instr    pc+1     cnt
    add_vec(0, 0, 16'h0, 1,   1, 16'h0000, 0, 16'h0000, 16'h0000, 3'd0); // C0
    add_vec(0, 0, 16'h0, 1,   1, 16'h0001, 0, 16'h0000, 16'h0000, 3'd0); // C1
    add_vec(0, 0, 16'h0, 1,   1, 16'h0002, 1, 16'h1000, 16'h0001, 3'd1); // C2
    add_vec(0, 0, 16'h0, 1,   1, 16'h0003, 1, 16'h1001, 16'h0002, 3'd1);
    add_vec(0, 0, 16'h0, 1,   1, 16'h0004, 1, 16'h1002, 16'h0003, 3'd1);
    add_vec(0, 0, 16'h0, 0,   1, 16'h0005, 1, 16'h1003, 16'h0004, 3'd1); // stall begins
    add_vec(0, 0, 16'h0, 0,   1, 16'h0006, 1, 16'h1003, 16'h0004, 3'd2);
    add_vec(0, 0, 16'h0, 0,   0, 16'h0007, 1, 16'h1003, 16'h0004, 3'd3);
    for (int i = 0; i < 7; i++)
      add_vec(0, 0, 16'h0, 0, 0, 16'h0007, 1, 16'h1003, 16'h0004, 3'd4);
    add_vec(0, 0, 16'h0, 1,   0, 16'h0007, 1, 16'h1003, 16'h0004, 3'd4); // resume
    add_vec(0, 0, 16'h0, 1,   1, 16'h0007, 1, 16'h1004, 16'h0005, 3'd3);
    add_vec(0, 0, 16'h0, 1,   1, 16'h0008, 1, 16'h1005, 16'h0006, 3'd2);
    add_vec(0, 0, 16'h0, 1,   1, 16'h0009, 1, 16'h1006, 16'h0007, 3'd2);
    add_vec(0, 0, 16'h0, 1,   1, 16'h000A, 1, 16'h1007, 16'h0008, 3'd2);
    add_vec(0, 0, 16'h0, 1,   1, 16'h000B, 1, 16'h1008, 16'h0009, 3'd2);
    add_vec(0, 0, 16'h0, 0,   1, 16'h000C, 1, 16'h1009, 16'h000A, 3'd2);
    add_vec(0, 1, 16'h0040, 1, 0, 16'h000D, 1, 16'h1009, 16'h000A, 3'd3); // redirect
    add_vec(0, 0, 16'h0, 1,   1, 16'h0040, 0, 16'h0000, 16'h0000, 3'd0);
    add_vec(0, 0, 16'h0, 1,   1, 16'h0041, 0, 16'h0000, 16'h0000, 3'd0);
    add_vec(0, 0, 16'h0, 1,   1, 16'h0042, 1, 16'h1040, 16'h0041, 3'd1);
    add_vec(0, 0, 16'h0, 1,   1, 16'h0043, 1, 16'h1041, 16'h0042, 3'd1);

    // Reset state
    rst = 1'b1; hlt = 1'b0; alt_pc_ctrl = 1'b0; alt_pc = '0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset out_valid",  32'(out_valid),  32'd0);
    chk("reset q_count",    32'(q_count),    32'd0);
    chk("reset instr",      32'(instr),      32'd0);
    chk("reset pc_plus_1",  32'(pc_plus_1),  32'd0);
    chk("reset imem_rd_en", 32'(imem_rd_en), 32'd0);
    chk("reset imem_addr",  32'(imem_addr),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Streaming, backpressure and redirect vectors, one per cycle from C0
    for (int i = 0; i < vecs.size(); i++) begin
      hlt = vecs[i].hlt; alt_pc_ctrl = vecs[i].alt;
      alt_pc = vecs[i].alt_pc; out_ready = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("c%0d imem_rd_en", i), 32'(imem_rd_en), 32'(vecs[i].e_rd));
      chk($sformatf("c%0d imem_addr", i),  32'(imem_addr),  32'(vecs[i].e_addr));
      chk($sformatf("c%0d out_valid", i),  32'(out_valid),  32'(vecs[i].e_val));
      chk($sformatf("c%0d instr", i),      32'(instr),      32'(vecs[i].e_instr));
      chk($sformatf("c%0d pc_plus_1", i),  32'(pc_plus_1),  32'(vecs[i].e_pcp1));
      chk($sformatf("c%0d q_count", i),    32'(q_count),    32'(vecs[i].e_cnt));
      @(posedge clk); #1;
    end
    alt_pc_ctrl = 1'b0;

    // Halt: no issue, in-flight fetch still lands, queue drains
    hlt = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("halt%0d imem_rd_en", k), 32'(imem_rd_en), 32'd0);
      if (out_valid) got.push_back(pc_plus_1);
      @(posedge clk); #1;
    end
    chk("halt drained count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("halt drain 0", 32'(got[0]), 32'h0043);
      chk("halt drain 1", 32'(got[1]), 32'h0044);
    end
    hlt = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      @(negedge clk);
      if (imem_rd_en) begin
        found = 1'b1;
        chk("resume imem_addr", 32'(imem_addr), 32'h0044);
      end
      @(posedge clk); #1;
    end
    chk("resume issued", 32'(found), 32'd1);
    next_out(8, ok, ins, pcp, lat);
    chk("resume out seen", 32'(ok), 32'd1);
    chk("resume instr", 32'(ins), 32'h1044);
    chk("resume pc_plus_1", 32'(pcp), 32'h0045);

    // Redirect to the top of the address space: pc_plus_1 wraps
    alt_pc_ctrl = 1'b1; alt_pc = 16'hFFFF;
    @(posedge clk); #1;
    alt_pc_ctrl = 1'b0;
    @(negedge clk);
    chk("wrap R+1 out_valid", 32'(out_valid), 32'd0);
    chk("wrap R+1 imem_rd_en", 32'(imem_rd_en), 32'd1);
    chk("wrap R+1 imem_addr", 32'(imem_addr), 32'h0000FFFF);
    @(posedge clk); #1;
    next_out(8, ok, ins, pcp, lat);
    chk("wrap first seen", 32'(ok), 32'd1);
    chk("wrap latency", 32'(lat), 32'd1);
    chk("wrap first instr", 32'(ins), 32'h0FFF);
    chk("wrap first pc_plus_1", 32'(pcp), 32'h0000);
    next_out(8, ok, ins, pcp, lat);
    chk("wrap second seen", 32'(ok), 32'd1);
    chk("wrap second instr", 32'(ins), 32'h1000);
    chk("wrap second pc_plus_1", 32'(pcp), 32'h0001);

    // Fill the queue, then reset mid-stream
    out_ready = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (q_count == 3'd4) begin
        found = 1'b1;
        chk("full imem_rd_en", 32'(imem_rd_en), 32'd0);
      end
      @(posedge clk); #1;
    end
    chk("queue reached full", 32'(found), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst q_count", 32'(q_count), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst imem_addr", 32'(imem_addr), 32'd0);
    chk("rst imem_rd_en", 32'(imem_rd_en), 32'd1);
    @(posedge clk); #1;
    next_out(8, ok, ins, pcp, lat);
    chk("post-rst seen", 32'(ok), 32'd1);
    chk("post-rst latency", 32'(lat), 32'd1);
    chk("post-rst instr", 32'(ins), 32'h1000);
    chk("post-rst pc_plus_1", 32'(pcp), 32'h0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage with a decoupling prefetch queue, placed between the program counter/instruction memory and the decode stage. It issues sequential word fetches to a synchronous-read instruction memory and buffers returned instructions with their `pc_plus_1`. Decode consumes them through a valid/ready handshake. The block also supports branch/jump redirect with queue flush, and a halt input.

## Interface
**Parameters**
- `ADDR_W`, 16, PC / instruction-address width in words.
- `INSTR_W`, 16, instruction width.
- `QDEPTH`, 4, prefetch-queue entries. Power of two, ≥2.
- `RESET_PC`, 0, first fetch address after reset.

**Ports**
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `hlt` in 1: level; while high no new fetch is issued.
- `alt_pc_ctrl` in 1: redirect request, one-cycle pulse.
- `alt_pc` in ADDR_W: redirect target.
- `imem_addr` out ADDR_W: fetch address.
- `imem_rd_en` out 1: fetch issue strobe.
- `imem_rdata` in INSTR_W: read data, valid the cycle after issue.
- `instr` out INSTR_W: queue-head instruction.
- `pc_plus_1` out ADDR_W: queue-head address + 1.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: decode accepts head.
- `q_count` out $clog2(QDEPTH)+1: occupied entries (debug).

## Operation
- **Reset values:**
  - `out_valid`=0, `q_count`=0, `instr`=0, `pc_plus_1`=0.
  - `imem_rd_en`=0, `imem_addr`=RESET_PC.
  - Fetch PC = RESET_PC, in-flight flag = 0, state = FETCH.
- **States:**
  - FETCH: issue allowed.
  - HALTED: entered when `hlt`=1; returns to FETCH on the cycle `hlt` samples 0.
  - Reset forces FETCH.
- **Issue rule:** `imem_rd_en`=1 iff all of the following hold:
  - state is FETCH,
  - `hlt`=0,
  - `alt_pc_ctrl`=0,
  - `q_count` + in-flight < QDEPTH.
  
  A same-cycle pop is not credited.
- **On issue:**
  - `imem_addr` = fetch PC.
  - Fetch PC ← fetch PC+1, modulo 2^ADDR_W; 0xFFFF wraps to 0x0000.
  - The in-flight tag records that address.
- **Response:** the cycle after issue, {`imem_rdata`, tag+1} is pushed to the queue, unless the response has been killed.
- **Pop:** when `out_valid` & `out_ready`, the head advances.
- **Empty queue:** `instr` and `pc_plus_1` are driven to 0.
- **Redirect (`alt_pc_ctrl`=1):**
  - Queue is cleared (`q_count`→0, `out_valid`→0 next cycle).
  - Any in-flight response is killed and never enqueued.
  - Fetch PC ← `alt_pc`.
  - A pop in the same cycle is ignored.
  - Redirect beats `hlt`: the PC is updated even in HALTED.
- **Simultaneous push+pop on a full queue** is impossible by the issue rule. Push+pop at any other occupancy leaves `q_count` unchanged.
- **`hlt` mid-operation:** an already-issued fetch still completes and enqueues. The queue continues to drain to decode.
- **`rst` mid-operation:** all state is restored to reset values on the next edge. The in-flight response is discarded.

## Timing
- Fetch issued in cycle N → data in the queue at the end of N+1 → `out_valid`=1 in cycle N+2 (2-cycle latency). No bypass.
- First `rst`-low cycle is C0:
  - C0: issue at RESET_PC.
  - C2: first `out_valid`.
- Steady state, with `out_ready` held high: one instruction per cycle.
- Redirect asserted in cycle R:
  - R+1: issue at `alt_pc`.
  - R+3: first redirected `out_valid`.
- Outputs `instr` and `pc_plus_1` are taken combinationally from queue head registers. `imem_rd_en` and `imem_addr` are combinational from registered state and inputs.

## Structure
- Package `fetch_pkg`:
  - `fetch_state_t` enum {FETCH, HALTED},
  - `fetch_entry_t` struct {instr, pc_plus_1},
  - default RESET_PC constant.
- Sub-module `fetch_fifo`: a circular buffer with push, pop and synchronous flush. Parametrised by depth and entry type. Wrapping read/write pointers plus a count.
- The top level holds the PC, in-flight/kill tracking and the state register.

## Test plan
1. Reset, `out_ready`=1, memory word k = 0x1000+k → `out_valid` rises 2 cycles after reset release. The stream is 0x1000, 0x1001, … with `pc_plus_1` = 1, 2, … at one per cycle.
2. `out_ready`=0 for 10 cycles → `q_count` saturates at QDEPTH=4, `imem_rd_en` drops. No entry is lost; resume yields in-order data.
3. `alt_pc_ctrl` pulse with `alt_pc`=0x0040 while an entry is in flight and 3 entries are queued → `out_valid`=0 next cycle. The next delivered `pc_plus_1`=0x0041. No pre-redirect instruction appears afterwards.
4. `hlt` high for 5 cycles → no `imem_rd_en` during that time. The in-flight fetch still enqueues and the queue drains. Fetch resumes at the next sequential PC.
5. Redirect to `alt_pc`=0xFFFF → `pc_plus_1` sequence 0x0000, 0x0001 (wrap).
6. `rst` asserted mid-stream with a full queue → next cycle `q_count`=0, `out_valid`=0, `imem_addr`=RESET_PC. The stale in-flight data is not delivered.
